// File: rtl/sprite_draw_engine_pkg.sv
// Shared game package for the sprite draw engine.
// Holds object index constants, colour constants, screen bounds, coordinate widths and the
// engine FSM state type.
package sprite_draw_engine_pkg;

    localparam int unsigned X_W     = 8;  // screen x coordinate width
    localparam int unsigned Y_W     = 7;  // screen y coordinate width
    localparam int unsigned SEL_W   = 4;  // object select width
    localparam int unsigned COL_W   = 3;  // {R,G,B}
    localparam int unsigned DIM_W   = 3;  // box width/height and walk counter width
    localparam int unsigned NUM_OBJ = 6;

    localparam logic [SEL_W-1:0] OBJ_PLAYER = 4'd0;
    localparam logic [SEL_W-1:0] OBJ_ENEMY1 = 4'd1;
    localparam logic [SEL_W-1:0] OBJ_ENEMY2 = 4'd2;
    localparam logic [SEL_W-1:0] OBJ_ENEMY3 = 4'd3;
    localparam logic [SEL_W-1:0] OBJ_ENEMY4 = 4'd4;
    localparam logic [SEL_W-1:0] OBJ_BULLET = 4'd5;

    localparam logic [COL_W-1:0] COL_BLACK  = 3'b000;
    localparam logic [COL_W-1:0] COL_PLAYER = 3'b010;
    localparam logic [COL_W-1:0] COL_ENEMY  = 3'b100;
    localparam logic [COL_W-1:0] COL_BULLET = 3'b110;

    // Sized one bit wider than the coordinates so pixel sums compare without truncation.
    localparam logic [X_W:0] SCREEN_W = 9'd160;
    localparam logic [Y_W:0] SCREEN_H = 8'd120;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StErase,
        StDraw,
        StDone
    } state_e;

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Sequencer/game-state <-> draw engine bundle.
// master: draw sequencer side (drives select, frame tick, object state; receives pixels/done).
// slave : draw engine side.
// Signals: draw_sel, frame_tick, player_x/y, enemy_x/y/alive, bullet_x/y/alive (to engine);
//          vga_x, vga_y, vga_colour, vga_plot, done, busy (from engine).
interface sprite_draw_engine_if;
    import sprite_draw_engine_pkg::*;

    logic [SEL_W-1:0]   draw_sel;
    logic               frame_tick;
    logic [X_W-1:0]     player_x;
    logic [Y_W-1:0]     player_y;
    logic [4*X_W-1:0]   enemy_x;
    logic [4*Y_W-1:0]   enemy_y;
    logic [3:0]         enemy_alive;
    logic [X_W-1:0]     bullet_x;
    logic [Y_W-1:0]     bullet_y;
    logic               bullet_alive;
    logic [X_W-1:0]     vga_x;
    logic [Y_W-1:0]     vga_y;
    logic [COL_W-1:0]   vga_colour;
    logic               vga_plot;
    logic               done;
    logic               busy;

    modport master (
        output draw_sel, frame_tick, player_x, player_y, enemy_x, enemy_y, enemy_alive,
               bullet_x, bullet_y, bullet_alive,
        input  vga_x, vga_y, vga_colour, vga_plot, done, busy
    );

    modport slave (
        input  draw_sel, frame_tick, player_x, player_y, enemy_x, enemy_y, enemy_alive,
               bullet_x, bullet_y, bullet_alive,
        output vga_x, vga_y, vga_colour, vga_plot, done, busy
    );

endinterface

// File: rtl/sprite_draw_engine_box_walker.sv
// Row-major box walker: cx runs fastest from 0..w-1, then cy advances, up to h-1.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   start_i        zero both counters
//   step_i         advance one pixel; wraps to (0,0) after the last pixel
//   w_i, h_i       box size (>= 1)
//   cx_o, cy_o     current offsets inside the box
//   last_o         current offset is the final pixel of the box
module sprite_draw_engine_box_walker
    import sprite_draw_engine_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [DIM_W-1:0] w_i,
    input  logic [DIM_W-1:0] h_i,
    output logic [DIM_W-1:0] cx_o,
    output logic [DIM_W-1:0] cy_o,
    output logic             last_o
);

    logic [DIM_W-1:0] cx_q, cx_d;
    logic [DIM_W-1:0] cy_q, cy_d;
    logic             last_col;
    logic             last_row;

    assign last_col = (cx_q == w_i - 3'd1);
    assign last_row = (cy_q == h_i - 3'd1);
    assign last_o   = last_col && last_row;
    assign cx_o     = cx_q;
    assign cy_o     = cy_q;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (start_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (step_i) begin
            if (last_col) begin
                cx_d = '0;
                // Wrapping after the last row lets DRAW follow ERASE without a restart.
                cy_d = last_row ? '0 : cy_q + 3'd1;
            end else begin
                cx_d = cx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/sprite_draw_engine.sv
// Sprite draw engine: for the object chosen by draw_sel, erases its previously drawn box in
// black, draws it at its current position, one VGA pixel write per cycle, then pulses done.
// A pass that starts at object 0 (player) waits for a frame tick.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus_io       slave side of sprite_draw_engine_if (select, object state in; pixels,
//                done, busy out)
module sprite_draw_engine
    import sprite_draw_engine_pkg::*;
#(
    parameter int unsigned SPR_W = 4,
    parameter int unsigned SPR_H = 4,
    parameter int unsigned BUL_W = 1,
    parameter int unsigned BUL_H = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_draw_engine_if.slave  bus_io
);

    localparam logic [DIM_W-1:0] SprWL = DIM_W'(SPR_W);
    localparam logic [DIM_W-1:0] SprHL = DIM_W'(SPR_H);
    localparam logic [DIM_W-1:0] BulWL = DIM_W'(BUL_W);
    localparam logic [DIM_W-1:0] BulHL = DIM_W'(BUL_H);

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [X_W-1:0]     cur_x_q;
    logic [Y_W-1:0]     cur_y_q;
    logic               alive_q;
    logic [DIM_W-1:0]   w_q;
    logic [DIM_W-1:0]   h_q;
    logic [COL_W-1:0]   col_q;
    logic               frame_pend_q;
    logic [NUM_OBJ-1:0] prev_valid_q;
    logic [X_W-1:0]     prev_x_q [NUM_OBJ];
    logic [Y_W-1:0]     prev_y_q [NUM_OBJ];

    // Object mux, indexed by the select captured on IDLE->LATCH.
    logic [X_W-1:0]     obj_x;
    logic [Y_W-1:0]     obj_y;
    logic               obj_alive;
    logic [DIM_W-1:0]   obj_w;
    logic [DIM_W-1:0]   obj_h;
    logic [COL_W-1:0]   obj_col;
    logic [1:0]         en_idx;
    logic [4:0]         ey_base;
    logic               sel_ok;
    logic [2:0]         tbl_idx;
    logic               prev_hit;

    // Enemy n = sel n+1; low two select bits minus one map 1..4 onto 0..3.
    assign en_idx   = sel_q[1:0] - 2'd1;
    assign ey_base  = 5'(en_idx) * 5'd7;
    assign sel_ok   = (sel_q < SEL_W'(NUM_OBJ));
    assign tbl_idx  = sel_q[2:0];
    assign prev_hit = sel_ok && prev_valid_q[tbl_idx];

    always_comb begin
        obj_x     = '0;
        obj_y     = '0;
        obj_alive = 1'b0;
        obj_w     = SprWL;
        obj_h     = SprHL;
        obj_col   = COL_BLACK;
        case (sel_q)
            OBJ_PLAYER: begin
                obj_x     = bus_io.player_x;
                obj_y     = bus_io.player_y;
                obj_alive = 1'b1;
                obj_col   = COL_PLAYER;
            end
            OBJ_ENEMY1, OBJ_ENEMY2, OBJ_ENEMY3, OBJ_ENEMY4: begin
                obj_x     = bus_io.enemy_x[{en_idx, 3'b000} +: X_W];
                obj_y     = bus_io.enemy_y[ey_base +: Y_W];
                obj_alive = bus_io.enemy_alive[en_idx];
                obj_col   = COL_ENEMY;
            end
            OBJ_BULLET: begin
                obj_x     = bus_io.bullet_x;
                obj_y     = bus_io.bullet_y;
                obj_alive = bus_io.bullet_alive;
                obj_w     = BulWL;
                obj_h     = BulHL;
                obj_col   = COL_BULLET;
            end
            default: ;
        endcase
    end

    // Box walker shared by ERASE and DRAW.
    logic [DIM_W-1:0] cx;
    logic [DIM_W-1:0] cy;
    logic             walk_last;
    logic             walking;

    assign walking = (state_q == StErase) || (state_q == StDraw);

    sprite_draw_engine_box_walker u_walker (
        .clk     (clk),
        .reset   (reset),
        .start_i (state_q == StLatch),
        .step_i  (walking),
        .w_i     (w_q),
        .h_i     (h_q),
        .cx_o    (cx),
        .cy_o    (cy),
        .last_o  (walk_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            alive_q      <= 1'b0;
            w_q          <= '0;
            h_q          <= '0;
            col_q        <= COL_BLACK;
            frame_pend_q <= 1'b0;
            prev_valid_q <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                prev_x_q[i] <= '0;
                prev_y_q[i] <= '0;
            end
        end else begin
            // A tick in the same cycle as the clear must not be lost.
            if (bus_io.frame_tick) begin
                frame_pend_q <= 1'b1;
            end else if (state_q == StLatch && sel_q == OBJ_PLAYER) begin
                frame_pend_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (bus_io.draw_sel != OBJ_PLAYER || frame_pend_q || bus_io.frame_tick) begin
                        sel_q   <= bus_io.draw_sel;
                        state_q <= StLatch;
                    end
                end
                StLatch: begin
                    cur_x_q <= obj_x;
                    cur_y_q <= obj_y;
                    alive_q <= obj_alive;
                    w_q     <= obj_w;
                    h_q     <= obj_h;
                    col_q   <= obj_col;
                    if (prev_hit) begin
                        state_q <= StErase;
                    end else if (obj_alive) begin
                        state_q <= StDraw;
                    end else begin
                        state_q <= StDone;
                    end
                end
                StErase: begin
                    if (walk_last) begin
                        state_q <= alive_q ? StDraw : StDone;
                    end
                end
                StDraw: begin
                    if (walk_last) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // Invalid selects leave the table untouched.
                    if (sel_ok) begin
                        if (alive_q) begin
                            prev_x_q[tbl_idx]     <= cur_x_q;
                            prev_y_q[tbl_idx]     <= cur_y_q;
                            prev_valid_q[tbl_idx] <= 1'b1;
                        end else begin
                            prev_valid_q[tbl_idx] <= 1'b0;
                        end
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Pixel outputs: base + offset, sums kept one bit wide so off-screen pixels are caught.
    logic [X_W-1:0] base_x;
    logic [Y_W-1:0] base_y;
    logic [X_W:0]   sx;
    logic [Y_W:0]   sy;
    logic           in_view;

    assign base_x  = (state_q == StErase) ? prev_x_q[tbl_idx] : cur_x_q;
    assign base_y  = (state_q == StErase) ? prev_y_q[tbl_idx] : cur_y_q;
    assign sx      = {1'b0, base_x} + {6'b0, cx};
    assign sy      = {1'b0, base_y} + {5'b0, cy};
    assign in_view = (sx < SCREEN_W) && (sy < SCREEN_H);

    assign bus_io.vga_x      = walking ? sx[X_W-1:0] : '0;
    assign bus_io.vga_y      = walking ? sy[Y_W-1:0] : '0;
    assign bus_io.vga_colour = (state_q == StDraw) ? col_q : COL_BLACK;
    assign bus_io.vga_plot   = walking && in_view;
    assign bus_io.done       = (state_q == StDone);
    assign bus_io.busy       = (state_q == StLatch) || walking;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Self-checking bench for sprite_draw_engine: expected pixels are pushed to a scoreboard
// queue from a small box model, observed plots are collected, and each scenario compares them.
module tb_sprite_draw_engine;
    import sprite_draw_engine_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_draw_engine_if bus ();

    sprite_draw_engine dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];

    // Model: row-major box with screen clipping.
    task automatic push_box(input int x, input int y, input int w, input int h,
                            input logic [2:0] col);
        for (int cy = 0; cy < h; cy++) begin
            for (int cx = 0; cx < w; cx++) begin
                if (x + cx < 160 && y + cy < 120) begin
                    exp_q.push_back({8'(x + cx), 7'(y + cy), col});
                end
            end
        end
    endtask

    // Cycle 1 is the first negedge; returns the cycle of done, or -1 if none within limit.
    task automatic collect(input int limit, output int done_cyc);
        done_cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (bus.vga_plot) got_q.push_back({bus.vga_x, bus.vga_y, bus.vga_colour});
            if (bus.done) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    task automatic visit(input logic [3:0] sel, input logic tick, input int limit,
                         output int done_cyc);
        @(posedge clk); #1;
        bus.draw_sel   = sel;
        bus.frame_tick = tick;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        collect(limit, done_cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.draw_sel = '0; bus.frame_tick = 1'b0;
        bus.player_x = 8'd10; bus.player_y = 7'd20;
        bus.enemy_x = '0; bus.enemy_y = '0; bus.enemy_alive = '0;
        bus.bullet_x = '0; bus.bullet_y = '0; bus.bullet_alive = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot} !== 19'd0) begin
            errors++;
            $display("FAIL reset_pixel got=%h want=0",
                     {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot});
        end
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=00", {bus.done, bus.busy});
        end
        reset = 1'b0;
    endtask

    task automatic test_first_draw();
        int dc;
        logic [17:0] e, g;
        push_box(10, 20, 4, 4, COL_PLAYER);
        visit(4'd0, 1'b1, 60, dc);
        checks++;
        if (dc !== 18) begin errors++; $display("FAIL t1_done got=%0d want=18", dc); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL t1_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL t1_pix got=%h want=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_move();
        int dc;
        logic [17:0] e, g;
        bus.player_x = 8'd11;
        push_box(10, 20, 4, 4, COL_BLACK);
        push_box(11, 20, 4, 4, COL_PLAYER);
        visit(4'd0, 1'b1, 60, dc);
        checks++;
        if (dc !== 34) begin errors++; $display("FAIL t2_done got=%0d want=34", dc); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL t2_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL t2_pix got=%h want=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_enemy_kill();
        int dc;
        int want_dc [3] = '{18, 18, 2};
        logic [17:0] e, g;
        bus.enemy_x[15:8] = 8'd50;
        bus.enemy_y[13:7] = 7'd30;
        bus.enemy_alive[1] = 1'b1;
        for (int v = 0; v < 3; v++) begin
            if (v == 0) push_box(50, 30, 4, 4, COL_ENEMY);
            if (v == 1) push_box(50, 30, 4, 4, COL_BLACK);
            visit(4'd2, 1'b0, 60, dc);
            checks++;
            if (dc !== want_dc[v]) begin
                errors++; $display("FAIL t3_done_v%0d got=%0d want=%0d", v, dc, want_dc[v]);
            end
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL t3_count_v%0d got=%0d want=%0d", v, got_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
                if (g !== e) begin errors++; $display("FAIL t3_pix got=%h want=%h", g, e); end
            end
            exp_q.delete(); got_q.delete();
            bus.enemy_alive[1] = 1'b0;
        end
    endtask

    task automatic test_clip();
        int dc;
        logic [17:0] e, g;
        // Bullet straddling the bottom edge.
        bus.bullet_x = 8'd158; bus.bullet_y = 7'd119; bus.bullet_alive = 1'b1;
        push_box(158, 119, 1, 2, COL_BULLET);
        visit(4'd5, 1'b0, 20, dc);
        checks++;
        if (dc !== 4) begin errors++; $display("FAIL t4_bul_done got=%0d want=4", dc); end
        // Enemy3 in the bottom-right corner: only a 2x2 corner is visible.
        bus.enemy_x[23:16] = 8'd158; bus.enemy_y[20:14] = 7'd118; bus.enemy_alive[2] = 1'b1;
        push_box(158, 118, 4, 4, COL_ENEMY);
        visit(4'd3, 1'b0, 60, dc);
        checks++;
        if (dc !== 18) begin errors++; $display("FAIL t4_en_done got=%0d want=18", dc); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL t4_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL t4_pix got=%h want=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_frame_gate();
        int dc;
        logic [17:0] e, g;
        @(posedge clk); #1;
        bus.draw_sel = 4'd0; bus.frame_tick = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL t5_wait busy=%b want=0", bus.busy); end
        end
        @(posedge clk); #1;
        bus.frame_tick = 1'b1;
        @(posedge clk); #1;  // now in LATCH; the tick stays high to collide with the clear
        @(negedge clk); checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL t5_latch busy=%b want=1", bus.busy); end
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        push_box(11, 20, 4, 4, COL_BLACK);
        push_box(11, 20, 4, 4, COL_PLAYER);
        collect(60, dc);
        checks++;
        if (dc !== 33) begin errors++; $display("FAIL t5_done1 got=%0d want=33", dc); end
        // Pending tick survived the clear, so the next pass starts without a new tick.
        push_box(11, 20, 4, 4, COL_BLACK);
        push_box(11, 20, 4, 4, COL_PLAYER);
        visit(4'd0, 1'b0, 60, dc);
        checks++;
        if (dc !== 34) begin errors++; $display("FAIL t5_done2 got=%0d want=34", dc); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL t5_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL t5_pix got=%h want=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
        visit(4'd0, 1'b0, 6, dc);
        checks++;
        if (dc !== -1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL t5_gated done=%0d busy=%b want=-1/0", dc, bus.busy);
        end
        got_q.delete();
    endtask

    task automatic test_reset_mid_draw();
        int dc;
        logic [17:0] e, g;
        bus.enemy_x[31:24] = 8'd70; bus.enemy_y[27:21] = 7'd50; bus.enemy_alive[3] = 1'b1;
        @(posedge clk); #1;
        bus.draw_sel = 4'd4;
        @(posedge clk); #1;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.vga_plot !== 1'b1) begin errors++; $display("FAIL t6_middraw plot=%b want=1", bus.vga_plot); end
        #2 reset = 1'b1;
        bus.draw_sel = 4'd0;
        #1 checks++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.done, bus.busy} !== 21'd0) begin
            errors++;
            $display("FAIL t6_async got=%h want=0",
                     {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.done, bus.busy});
        end
        @(negedge clk);
        reset = 1'b0;
        got_q.delete();
        push_box(70, 50, 4, 4, COL_ENEMY);
        visit(4'd4, 1'b0, 60, dc);
        checks++;
        if (dc !== 18) begin errors++; $display("FAIL t6_en_done got=%0d want=18", dc); end
        push_box(11, 20, 4, 4, COL_PLAYER);
        visit(4'd0, 1'b1, 60, dc);
        checks++;
        if (dc !== 18) begin errors++; $display("FAIL t6_pl_done got=%0d want=18", dc); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL t6_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL t6_pix got=%h want=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_move();
        test_enemy_kill();
        test_clip();
        test_frame_gate();
        test_reset_mid_draw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
